// File: rtl/seg7_pkg.sv
// Shared state encoding, display constants and segment table for seg7_scan.
package seg7_pkg;

  typedef logic [1:0] state_t;

  localparam state_t DIG0 = 2'd0;
  localparam state_t GAP0 = 2'd1;
  localparam state_t DIG1 = 2'd2;
  localparam state_t GAP1 = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [1:0] AN_OFF    = 2'b11;

  // Active-low patterns for digits 0..9, bit0=a .. bit6=g.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit to active-low segment decoder; non-decimal inputs blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    if (digit <= 4'd9) seg_n = SEG_TABLE[digit];
  end

endmodule

// File: rtl/seg7_scan.sv
// Two-digit multiplexed 7-segment scanner with per-frame snapshot and blanking gaps.
// Optional leading-zero blanking of the tens digit via SEG7_LZB_EN.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned GAP_CYC  = 100
) (
  input  logic       clk_100m,
  input  logic       xreset,
  input  logic [3:0] count,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       frame_tick
);

  localparam int unsigned TW = $clog2(max_u(SCAN_DIV, GAP_CYC));
  localparam logic [TW-1:0] DIG_LAST = TW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    snap_q, snap_d;
  logic          last;
  logic          tens;
  logic [3:0]    ones;
  logic [6:0]    seg_ones, seg_tens;
  logic [6:0]    seg_d;
  logic [1:0]    an_d;
  logic          tick_d;

  always_comb begin
    last    = (state_q == DIG0 || state_q == DIG1) ? (timer_q == DIG_LAST)
                                                   : (timer_q == GAP_LAST);
    timer_d = last ? '0 : timer_q + 1'b1;
    state_d = state_q;
    if (last) begin
      unique case (state_q)
        DIG0:    state_d = GAP0;
        GAP0:    state_d = DIG1;
        DIG1:    state_d = GAP1;
        default: state_d = DIG0;
      endcase
    end
  end

  // The snapshot feeds the output registers on the same edge it is taken,
  // so the first DIG0 cycle already shows the new value.
  assign snap_d = (last && state_q == GAP1) ? count : snap_q;
  assign tens   = (snap_d >= 4'd10);
  assign ones   = tens ? snap_d - 4'd10 : snap_d;

  seg7_decode u_dec_ones (
    .digit (ones),
    .seg_n (seg_ones)
  );

  seg7_decode u_dec_tens (
    .digit ({3'b000, tens}),
    .seg_n (seg_tens)
  );

  always_comb begin
    seg_d  = SEG_BLANK;
    an_d   = AN_OFF;
    tick_d = last && (state_q == GAP1);
    unique case (state_d)
      DIG0: begin
        an_d  = 2'b10;
        seg_d = seg_ones;
      end
      DIG1: begin
        // Anode stays driven when blanked so per-digit duty cycle is unchanged.
        an_d  = 2'b01;
`ifdef SEG7_LZB_EN
        seg_d = tens ? seg_tens : SEG_BLANK;
`else
        seg_d = seg_tens;
`endif
      end
      default: begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk_100m or negedge xreset) begin
    if (!xreset) begin
      state_q    <= GAP1;
      timer_q    <= '0;
      snap_q     <= 4'd0;
      seg_n      <= SEG_BLANK;
      an_n       <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      snap_q     <= snap_d;
      seg_n      <= seg_d;
      an_n       <= an_d;
      frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan with SCAN_DIV=4, GAP_CYC=2 (12-cycle frame).
module tb_seg7_scan;

  logic       clk_100m = 1'b0;
  logic       clk_en   = 1'b0;
  logic       xreset   = 1'b1;
  logic [3:0] count    = 4'd0;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  logic       frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SEG7_LZB_EN
  localparam logic [6:0] TENS0 = 7'h7F;
`else
  localparam logic [6:0] TENS0 = 7'h40;
`endif

  seg7_scan #(
    .SCAN_DIV (4),
    .GAP_CYC  (2)
  ) dut (
    .clk_100m   (clk_100m),
    .xreset     (xreset),
    .count      (count),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  always #5 if (clk_en) clk_100m = ~clk_100m;

  // Pulse reset between edges; the next posedge is edge 1 after release.
  task automatic restart(input logic [3:0] v);
    @(negedge clk_100m);
    count  = v;
    xreset = 1'b0;
    #2;
    xreset = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    xreset = 1'b0;
    #1;
    n_checks++;
    if (seg_n !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_seg: got %h want 7f", seg_n);
    end
    n_checks++;
    if (an_n !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_an: got %b want 11", an_n);
    end
    n_checks++;
    if (frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tick: got %b want 0", frame_tick);
    end
    clk_en = 1'b1;
    @(negedge clk_100m);
    xreset = 1'b1;
  endtask

  task automatic test_hold(input string name, input logic [3:0] v,
                           input logic [6:0] o, input logic [6:0] t);
    logic [1:0] ea;
    logic [6:0] es;
    logic       et;
    int         p;
    restart(v);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk_100m);
      ea = 2'b11; es = 7'h7F; et = 1'b0;
      if (k >= 2) begin
        p = (k - 2) % 12;
        if (p < 4) begin ea = 2'b10; es = o; et = (p == 0); end
        else if (p >= 6 && p < 10) begin ea = 2'b01; es = t; end
      end
      n_checks++;
      if ({an_n, seg_n, frame_tick} !== {ea, es, et}) begin
        n_fail++;
        $display("FAIL %s k=%0d: got an=%b seg=%h tick=%b want an=%b seg=%h tick=%b",
                 name, k, an_n, seg_n, frame_tick, ea, es, et);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [1:0] ea;
    logic [6:0] es, o, t;
    logic       et;
    int         p;
    restart(4'd5);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk_100m);
      o = (k <= 13) ? 7'h12 : 7'h24;
      t = (k <= 13) ? TENS0 : 7'h79;
      ea = 2'b11; es = 7'h7F; et = 1'b0;
      if (k >= 2) begin
        p = (k - 2) % 12;
        if (p < 4) begin ea = 2'b10; es = o; et = (p == 0); end
        else if (p >= 6 && p < 10) begin ea = 2'b01; es = t; end
      end
      n_checks++;
      if ({an_n, seg_n, frame_tick} !== {ea, es, et}) begin
        n_fail++;
        $display("FAIL snapshot k=%0d: got an=%b seg=%h tick=%b want an=%b seg=%h tick=%b",
                 k, an_n, seg_n, frame_tick, ea, es, et);
      end
      if (k == 3) count = 4'd12;
    end
  endtask

  task automatic test_reset_mid();
    restart(4'd3);
    repeat (9) @(negedge clk_100m);
    n_checks++;
    if (an_n !== 2'b01 || seg_n !== TENS0) begin
      n_fail++;
      $display("FAIL mid_pre_dig1: got an=%b seg=%h want an=01 seg=%h", an_n, seg_n, TENS0);
    end
    count  = 4'd9;
    xreset = 1'b0;
    #1;
    n_checks++;
    if ({an_n, seg_n, frame_tick} !== {2'b11, 7'h7F, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_blank: got an=%b seg=%h tick=%b want an=11 seg=7f tick=0",
               an_n, seg_n, frame_tick);
    end
    @(posedge clk_100m);
    #1;
    n_checks++;
    if ({an_n, seg_n} !== {2'b11, 7'h7F}) begin
      n_fail++;
      $display("FAIL mid_held: got an=%b seg=%h want an=11 seg=7f", an_n, seg_n);
    end
    @(negedge clk_100m);
    #2;
    xreset = 1'b1;
    @(negedge clk_100m);
    n_checks++;
    if ({an_n, seg_n, frame_tick} !== {2'b11, 7'h7F, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_gap1: got an=%b seg=%h tick=%b want an=11 seg=7f tick=0",
               an_n, seg_n, frame_tick);
    end
    @(negedge clk_100m);
    n_checks++;
    if ({an_n, seg_n, frame_tick} !== {2'b10, 7'h10, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_dig0: got an=%b seg=%h tick=%b want an=10 seg=10 tick=1",
               an_n, seg_n, frame_tick);
    end
  endtask

  task automatic test_free_run();
    int last_tick = -1;
    int ticks     = 0;
    restart(4'd0);
    for (int k = 1; k <= 61; k++) begin
      @(negedge clk_100m);
      n_checks++;
      if (an_n === 2'b00) begin
        n_fail++;
        $display("FAIL free_an k=%0d: got an=%b want not 00", k, an_n);
      end
      if (an_n === 2'b11) begin
        n_checks++;
        if (seg_n !== 7'h7F) begin
          n_fail++;
          $display("FAIL free_blank k=%0d: got seg=%h want 7f", k, seg_n);
        end
      end
      if (frame_tick === 1'b1) begin
        n_checks++;
        if ((last_tick < 0 && k != 2) || (last_tick >= 0 && k - last_tick != 12)) begin
          n_fail++;
          $display("FAIL free_period k=%0d: got prev tick at %0d want spacing 12 (first at 2)",
                   k, last_tick);
        end
        last_tick = k;
        ticks++;
      end
      count = 4'(k);
    end
    n_checks++;
    if (ticks != 5) begin
      n_fail++;
      $display("FAIL free_ticks: got %0d want 5", ticks);
    end
  endtask

  initial begin
    test_reset();
    test_hold("hold7", 4'd7, 7'h78, TENS0);
    test_hold("hold13", 4'd13, 7'h30, 7'h79);
    test_hold("hold15", 4'd15, 7'h12, 7'h79);
    test_snapshot();
    test_reset_mid();
    test_free_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Downstream consumer of the 4-bit `counter` output. Shows `count` (0..15) in decimal on a 2-digit, time-multiplexed, common-anode 7-segment display.
- Takes a snapshot of `count` once per frame so both digits always show the same value.
- Inserts blanking gaps between digits to prevent ghosting.
- Sits between the counter and the board display pins.

Parameters:
- SCAN_DIV, 100000, cycles each digit is driven (1 ms at 100 MHz); legal range >=2.
- GAP_CYC, 100, blanking cycles after each digit; legal range >=1.

Ports:
- clk_100m  in  1  system clock, 100 MHz.
- xreset  in  1  reset, asynchronous, active-low.
- count  in  4  value from counter; unsigned 0..15.
- seg_n  out  7  segments, active-low; bit0=a .. bit6=g.
- an_n  out  2  digit anodes, active-low; bit0=ones digit, bit1=tens digit.
- frame_tick  out  1  one-cycle pulse on the first cycle of each frame.

Behaviour:
- Reset: one clock domain. xreset low asynchronously forces the following, with no clock edge needed:
  - state=GAP1, timer=0, snap=0
  - seg_n=7'h7F, an_n=2'b11, frame_tick=0
- FSM states: DIG0 -> GAP0 -> DIG1 -> GAP1 -> DIG0.
  - DIG states last SCAN_DIV cycles; GAP states last GAP_CYC cycles.
  - timer counts 0..N-1 and the state advances on the edge where timer==N-1; timer then clears.
  - Timer width is $clog2(max(SCAN_DIV,GAP_CYC)).
- Frame length is 2*(SCAN_DIV+GAP_CYC) cycles.
- Snapshot: on the GAP1->DIG0 edge, snap<=count. `count` changes at any other time have no effect until the next frame.
- BCD split:
  - tens = (snap>=10) ? 1 : 0
  - ones = (snap>=10) ? snap-10 : snap
- All outputs are registered and change on the same edge as state. There is no extra latency beyond the state.
  - DIG0: an_n=2'b10, seg_n=pattern(ones).
  - DIG1: an_n=2'b01, seg_n=pattern(tens).
  - GAP0/GAP1: an_n=2'b11, seg_n=7'h7F.
- frame_tick is 1 only in the first cycle of DIG0.
- Segment patterns (seg_n hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - blank=7F
- After xreset release, the first DIG0 cycle begins GAP_CYC rising edges later. The first frame_tick occurs then.
- Reset mid-frame blanks the display immediately. After release the block restarts from GAP1 and discards the old snap.
- Wrap: the counter rolling 15->0 is shown as 15 until the next snapshot. No special handling.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- Defined: in DIG1 with tens==0, seg_n=7'h7F, while an_n is still driven 2'b01 to keep timing and brightness uniform.
- Undefined: the tens digit always shows its pattern ("0"=7'h40).

Decomposition:
- Package seg7_pkg holds:
  - the state enum typedef {DIG0,GAP0,DIG1,GAP1}
  - constants SEG_BLANK=7'h7F and AN_OFF=2'b11
  - the 10-entry segment pattern table as a constant array
- Sub-module seg7_decode: purely combinational 4-bit digit -> 7-bit seg_n. Inputs >9 give SEG_BLANK.
- Top module holds the timer, FSM, snapshot, BCD split and output registers.

Test Plan (SCAN_DIV=4, GAP_CYC=2, frame=12 cycles):
- Reset: xreset=0 at arbitrary time, no clock -> seg_n=7F, an_n=11, frame_tick=0 immediately.
- count=7 held -> after 2 gap cycles:
  - 4 cycles an_n=10/seg_n=78, then 2 blank cycles
  - then 4 cycles an_n=01/seg_n=40 (7F with SEG7_LZB_EN), then 2 blank cycles
- count=13 held -> DIG0 seg_n=30, DIG1 seg_n=79 in both builds.
- count changes 5->12 on the 2nd cycle of DIG0 -> the rest of that frame shows 12 (DIG0) / 40 (DIG1). The next frame shows 24/79.
- xreset pulsed low during DIG1 -> immediate blank. After release, exactly 2 blank cycles, then DIG0 with frame_tick=1 and a fresh snapshot.
- Free run of 5 frames -> frame_tick period is exactly 12 cycles and 1 cycle wide. an_n is never 2'b00. seg_n=7F whenever an_n=11.
